// File: rtl/loop_sequencer.sv
// loop_sequencer: re-triggerable hardware loop engine emitting 0, step, 2*step, ... below a limit.
// Latency: first index valid the cycle after start is accepted; one index per cycle with ready high.
// Backpressure: out_valid && !out_ready holds out_data, idx and count; out_valid never depends on out_ready.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               command strobe, accepted only in IDLE
//   limit/step/brk_*    loop parameters latched on an accepted start (step 0 is used as 1)
//   out_data/valid/ready index stream
//   busy, done          busy in RUN and DONE; done pulses for the single DONE cycle
//   broke, wrapped      sticky end-reason flags, cleared by the next accepted start
//   count               number of indices transferred in the last/current loop
module loop_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  input  logic             brk_en,
  input  logic [WIDTH-1:0] brk_val,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             broke,
  output logic             wrapped,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] idx;
  logic [WIDTH-1:0] lim_q;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] brk_val_q;
  logic             brk_en_q;

  logic             at_limit;
  logic             at_brk;
  logic             fire;
  logic [WIDTH:0]   sum;

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    fire      = 1'b0;
    at_limit  = (idx >= lim_q);
    at_brk    = brk_en_q && (idx == brk_val_q);
    // Extra carry bit detects an index step past 2^WIDTH-1.
    sum       = {1'b0, idx} + {1'b0, step_q};
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        // Limit is checked before break so a coincident break value does not set broke.
        if (at_limit) begin
          state_nxt = DONE;
        end else if (at_brk) begin
          state_nxt = DONE;
        end else begin
          out_valid = 1'b1;
          fire      = out_ready;
          if (fire && sum[WIDTH]) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      lim_q     <= '0;
      step_q    <= WIDTH'(1);
      brk_val_q <= '0;
      brk_en_q  <= 1'b0;
      count     <= '0;
      broke     <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            lim_q     <= limit;
            step_q    <= (step == '0) ? WIDTH'(1) : step;
            brk_en_q  <= brk_en;
            brk_val_q <= brk_val;
            idx       <= '0;
            count     <= '0;
            broke     <= 1'b0;
            wrapped   <= 1'b0;
          end
        end
        RUN: begin
          if (!at_limit && at_brk) broke <= 1'b1;
          if (fire) begin
            count <= count + 1'b1;
            // On wrap idx is left alone; the loop ends on this transfer.
            if (sum[WIDTH]) wrapped <= 1'b1;
            else            idx     <= sum[WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data = idx;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_loop_sequencer.sv
// tb_loop_sequencer: directed self-checking bench for loop_sequencer (WIDTH=4).
// Inputs driven and outputs sampled on the falling edge; DUT registers on the rising edge.
// Each loop's transferred indices are collected and compared against hand-computed lists.
module tb_loop_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] step;
  logic             brk_en;
  logic [WIDTH-1:0] brk_val;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             broke;
  logic             wrapped;
  logic [CNT_W-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  int got[$];
  int exp_q[$];

  always #5 clk = ~clk;

  loop_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .limit(limit), .step(step),
    .brk_en(brk_en), .brk_val(brk_val), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .broke(broke), .wrapped(wrapped), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; leaves the bench at the first RUN cycle's falling edge.
  task automatic do_start(input int lim, input int stp, input int be, input int bv);
    limit   = WIDTH'(lim);
    step    = WIDTH'(stp);
    brk_en  = be[0];
    brk_val = WIDTH'(bv);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready high every third cycle;
  // mode 2: ready high, plus stray start pulses mid-loop and in the DONE cycle.
  task automatic run_collect(input int mode, input string tag, output int done_idx);
    logic             prev_stall;
    logic [WIDTH-1:0] prev_d;
    prev_stall = 1'b0;
    prev_d     = '0;
    done_idx   = -1;
    got.delete();
    for (int c = 0; c < 60; c++) begin
      out_ready = (mode == 1) ? ((c % 3) == 0) : 1'b1;
      if (prev_stall) chk({tag, "_hold"}, out_data, prev_d);
      if (mode == 2) begin
        start = (c == 3);
        limit = 4'd1;
        step  = 4'd3;
      end
      if (out_valid && out_ready) got.push_back(int'(out_data));
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      if (done) begin
        done_idx = c;
        if (mode == 2) start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_done_pulse"}, done, 0);
        break;
      end
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic run_case(input string tag, input int lim, input int stp, input int be,
                          input int bv, input int mode, input int exp_done,
                          input int exp_broke, input int exp_wrap);
    int di;
    do_start(lim, stp, be, bv);
    chk({tag, "_busy"}, busy, 1);
    run_collect(mode, tag, di);
    chk({tag, "_done_idx"}, di, exp_done);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_data%0d", tag, i), (i < got.size()) ? got[i] : 32'hffff_ffff, exp_q[i]);
    // One cycle after DONE: back in IDLE with results held.
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_valid"}, out_valid, 0);
    chk({tag, "_count"}, count, exp_q.size());
    chk({tag, "_broke"}, broke, exp_broke);
    chk({tag, "_wrapped"}, wrapped, exp_wrap);
    @(negedge clk);
    chk({tag, "_still_idle"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; limit = '0; step = '0; brk_en = 1'b0; brk_val = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_broke", broke, 0);
    chk("rst_wrapped", wrapped, 0);
    rst = 1'b0;
    @(negedge clk);

    exp_q = {0, 1, 2, 3, 4, 5, 6, 7};
    run_case("brk8", 15, 1, 1, 8, 0, 9, 1, 0);

    exp_q = {0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
    run_case("lim15", 15, 1, 0, 0, 0, 16, 0, 0);

    exp_q.delete();
    run_case("lim0", 0, 1, 0, 0, 0, 1, 0, 0);

    exp_q = {0, 6, 12};
    run_case("wrap6", 15, 6, 0, 0, 0, 3, 0, 1);

    exp_q = {0, 1, 2};
    run_case("step0", 3, 0, 0, 0, 0, 4, 0, 0);

    exp_q.delete();
    run_case("brk0", 10, 1, 1, 0, 0, 1, 1, 0);

    exp_q = {0, 3, 6, 9};
    run_case("brkskip", 10, 3, 1, 5, 0, 5, 0, 0);

    exp_q = {0, 1, 2, 3};
    run_case("brklim", 4, 1, 1, 4, 0, 5, 0, 0);

    exp_q = {0, 1, 2, 3, 4};
    run_case("bp", 5, 1, 0, 0, 1, 14, 0, 0);

    exp_q = {0, 1, 2, 3, 4, 5};
    run_case("restart", 6, 1, 0, 0, 2, 7, 0, 0);

    // Reset while the third index is on the bus: immediate abort, no done pulse.
    do_start(15, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rstrun_data", out_data, 2);
    chk("rstrun_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstrun_valid_after", out_valid, 0);
    chk("rstrun_busy_after", busy, 0);
    chk("rstrun_count_after", count, 0);
    chk("rstrun_done_after", done, 0);
    @(negedge clk);
    chk("rstrun_no_done", done, 0);

    exp_q = {0, 1, 2};
    run_case("postrst", 3, 1, 0, 0, 0, 4, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/loop_sequencer.md
Name: loop_sequencer

Overview:
Parametrised hardware loop engine. It replaces the single-shot, initial-block counting loop with a synthesizable, re-triggerable sequencer. A start command latches a limit, a step and an optional break value. The block then emits the index sequence 0, step, 2*step, ... over a valid/ready stream until the index reaches the limit, hits the break value, or would wrap past 2^WIDTH-1. It sits between a command source and any consumer of the loop indices, for example an address generator or a display/log stage.

Parameters:
WIDTH, 4, bit width of index, limit, break value, step and emitted data
CNT_W, WIDTH+1, width of the emitted-value counter (holds up to 2^WIDTH)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  command strobe, accepted only in IDLE
limit  in  WIDTH  exclusive upper bound; loop runs while idx < limit
step  in  WIDTH  index increment; 0 is treated as 1
brk_en  in  1  enable early termination on break value
brk_val  in  WIDTH  index value that terminates the loop (not emitted)
out_data  out  WIDTH  current index
out_valid  out  1  out_data is valid
out_ready  in  1  consumer accepts out_data when out_valid && out_ready
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse at loop completion
broke  out  1  sticky until next accepted start: loop ended on break value
wrapped  out  1  sticky until next accepted start: loop ended on arithmetic wrap
count  out  CNT_W  number of values transferred in last/current loop

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE; idx=0; out_data=0; out_valid=0; busy=0; done=0; broke=0; wrapped=0; count=0. Reset mid-RUN aborts at once, with no done pulse.
- Three states: IDLE, RUN, DONE.
- IDLE: on start=1 at edge T, latch limit, brk_en, brk_val and step (0 becomes 1); set idx=0, count=0, broke=0, wrapped=0; go to RUN at T+1. busy rises at T+1.
- Start while busy is ignored. Latched parameters do not change mid-loop.
- RUN, evaluated each cycle from registers (priority order):
  1. idx >= limit: go to DONE (natural end), out_valid=0.
  2. brk_en && idx == brk_val: go to DONE, set broke=1, out_valid=0.
  3. Otherwise out_valid=1 and out_data=idx. On out_valid && out_ready:
     - count increments.
     - Compute sum = idx + step at WIDTH+1 bits. If sum[WIDTH]=1, go to DONE with wrapped=1.
     - Otherwise idx = sum[WIDTH-1:0].
- out_valid/out_data are combinational from state and idx registers only, with no combinational path from out_ready.
- Backpressure: while out_valid && !out_ready, out_data, idx and count hold.
- Latency: the first value is valid the cycle after start is accepted. With out_ready held high, one value is emitted per cycle. DONE follows the cycle after the last transfer (or the first RUN cycle for an empty loop).
- DONE: done=1 for exactly one cycle; next state IDLE. busy stays 1 during DONE and falls on return to IDLE.
  - start asserted during DONE is ignored.
  - broke, wrapped and count hold until the next accepted start.
- limit=0 gives an empty loop: RUN for one cycle with no output, then DONE.
- brk_val=0 with brk_en=1 gives an immediate break with no output and broke=1.
- A break value that the stepped sequence skips has no effect.
- Simultaneous break and limit (idx==brk_val and idx>=limit): the limit wins, so broke=0.

Test Plan:
- WIDTH=4, start with limit=15, brk_en=1, brk_val=8, step=1, out_ready=1 -> out_data 0..7 on 8 consecutive cycles starting one cycle after start; then done pulse; broke=1, count=8.
- limit=15, brk_en=0, step=1 -> 0..14 emitted; done; broke=0, wrapped=0, count=15. limit=0 -> no out_valid; done two cycles after start; count=0.
- limit=15, step=6, brk_en=0 -> 0,6,12 emitted; 12+6 wraps, so 2 is NOT emitted; done; wrapped=1, count=3. step=0 with limit=3 -> 0,1,2 emitted.
- limit=5, step=1, out_ready toggled 1,0,0,1,... -> out_data holds stable while ready=0; the sequence is still exactly 0..4 with no duplicates or drops; count=5.
- start pulsed again mid-loop and during the done cycle -> ignored; the sequence continues unchanged. rst=1 during the third value -> next cycle out_valid=0, busy=0, count=0, no done pulse; a new start then runs normally from 0.
